// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing for the reset sequencer.
// Pure declarations: no logic, no latency.
package rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_ASSERT    = 3'd4
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_LOCK_FILTER = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_GAP   = 8;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/rst_sync.sv
// STAGES-deep synchronizer with async active-low clear; q follows d after STAGES clk edges.
// No handshake: q is a level, cleared immediately while rst_n is low.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Releases NUM_DOMAINS active-low resets in index order once PLL lock is qualified.
// Outputs are registered; any lock loss or soft reset in RUN drops every domain together.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pll_locked,
  input  logic                   soft_rst,
  output logic [NUM_DOMAINS-1:0] dom_rstn,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [STATE_W-1:0]     state_o
);

  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

  logic rst_int_n;
  logic lock_s;

  rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .rst_n (rstn),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  rst_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rstn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    ready_d = ready_q;
    lost_d  = lost_q;

    unique case (state_q)
      // The shared counter counts up here as the lock filter, down everywhere else.
      S_WAIT_LOCK: begin
        dom_d   = '0;
        ready_d = 1'b0;
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_ASSERT;
          dom_d   = '0;
          ready_d = 1'b0;
          cnt_d   = HOLD_LD;
          idx_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_RELEASE;
          dom_d   = DOM_ONE;
          cnt_d   = GAP_LD;
          idx_d   = IDX_W'(1);
        end
      end

      S_RELEASE: begin
        if (!lock_s) begin
          state_d = S_ASSERT;
          dom_d   = '0;
          ready_d = 1'b0;
          cnt_d   = HOLD_LD;
          idx_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else begin
          dom_d = dom_q | (DOM_ONE << idx_q);
          idx_d = idx_q + 1'b1;
          cnt_d = GAP_LD;
        end
      end

      S_RUN: begin
        ready_d = 1'b1;
        if (!lock_s || soft_rst) begin
          state_d = S_ASSERT;
          dom_d   = '0;
          ready_d = 1'b0;
          cnt_d   = HOLD_LD;
          idx_d   = '0;
          if (!lock_s) begin
            lost_d = 1'b1;
          end
        end
      end

      S_ASSERT: begin
        dom_d   = '0;
        ready_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_WAIT_LOCK;
        dom_d   = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  assign dom_rstn  = dom_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer with default parameters: a timing table relative to T0 feeds
// a cycle-stamped scoreboard that is compared on the falling clock edge.
module tb_rst_sequencer;

  localparam int N    = 4;
  localparam int NTBL = 13;

  logic         clk = 1'b0;
  logic         rstn;
  logic         pll_locked;
  logic         soft_rst;
  logic [N-1:0] dom_rstn;
  logic         ready;
  logic         lock_lost;
  logic [2:0]   state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         off;
    logic [3:0] dom;
    logic       rdy;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    int         cyc;
    int         off;
    logic [8:0] exp;
    string      name;
  } sb_t;

  vec_t tbl [NTBL];
  sb_t  sb [$];

  rst_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .dom_rstn   (dom_rstn),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Falling-edge checker: pops every entry stamped for the current cycle.
  always @(negedge clk) begin
    logic [8:0] act;
    sb_t        e;
    act = {dom_rstn, ready, lock_lost, state_o};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s off=%0d: sample for cycle %0d missed (now %0d)", e.name, e.off, e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s off=%0d cyc=%0d: got dom=%b rdy=%b ll=%b st=%0d, want dom=%b rdy=%b ll=%b st=%0d",
                 e.name, e.off, cyc, act[8:5], act[4], act[3], act[2:0],
                 e.exp[8:5], e.exp[4], e.exp[3], e.exp[2:0]);
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input int off, input logic [8:0] e, input string nm);
    sb_t x;
    x.cyc  = c;
    x.off  = off;
    x.exp  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic push_table(input int t0, input logic ll, input int max_off, input string nm);
    for (int i = 0; i < NTBL; i++) begin
      if (tbl[i].off <= max_off) begin
        push(t0 + tbl[i].off, tbl[i].off, {tbl[i].dom, tbl[i].rdy, ll, tbl[i].st}, nm);
      end
    end
  endtask

  initial begin
    int t0;
    int s;
    int d;
    int k;
    int a;
    logic [8:0] act;

    // Expected trace with defaults: filter 4, hold 16, gap 8.
    tbl[0]  = '{0,  4'b0000, 1'b0, 3'd0};
    tbl[1]  = '{3,  4'b0000, 1'b0, 3'd0};
    tbl[2]  = '{4,  4'b0000, 1'b0, 3'd1};
    tbl[3]  = '{19, 4'b0000, 1'b0, 3'd1};
    tbl[4]  = '{20, 4'b0001, 1'b0, 3'd2};
    tbl[5]  = '{27, 4'b0001, 1'b0, 3'd2};
    tbl[6]  = '{28, 4'b0011, 1'b0, 3'd2};
    tbl[7]  = '{35, 4'b0011, 1'b0, 3'd2};
    tbl[8]  = '{36, 4'b0111, 1'b0, 3'd2};
    tbl[9]  = '{43, 4'b0111, 1'b0, 3'd2};
    tbl[10] = '{44, 4'b1111, 1'b0, 3'd2};
    tbl[11] = '{51, 4'b1111, 1'b0, 3'd2};
    tbl[12] = '{52, 4'b1111, 1'b1, 3'd3};

    rstn       = 1'b0;
    pll_locked = 1'b1;
    soft_rst   = 1'b0;

    // Cold boot with lock already present; soft_rst in HOLD must be ignored.
    goto(3);
    push(cyc, 0, 9'b0000_0_0_000, "reset");
    goto(5);
    rstn = 1'b1;
    t0   = cyc + 2;
    push_table(t0, 1'b0, 99, "boot");
    goto(t0 + 10);
    soft_rst = 1'b1;
    goto(t0 + 11);
    soft_rst = 1'b0;

    // soft_rst in RUN: 16 cycles of reset, then re-sequence.
    goto(t0 + 56);
    s = cyc;
    soft_rst = 1'b1;
    push(s + 1,  1,  9'b0000_0_0_100, "soft_run");
    push(s + 16, 16, 9'b0000_0_0_100, "soft_run");
    t0 = s + 17;
    push_table(t0, 1'b0, 28, "soft_reseq");
    goto(s + 1);
    soft_rst = 1'b0;

    // Lock drop seen by the FSM at T0+30, mid-release.
    goto(t0 + 28);
    pll_locked = 1'b0;
    push(t0 + 30, 30, 9'b0011_0_0_010, "drop_rel");
    push(t0 + 31, 31, 9'b0000_0_0_100, "drop_rel");
    push(t0 + 46, 46, 9'b0000_0_0_100, "drop_rel");
    goto(t0 + 29);
    pll_locked = 1'b1;
    t0 = t0 + 47;
    push_table(t0, 1'b0, 99, "relock");

    // Lock drop in RUN sets the sticky flag.
    goto(t0 + 55);
    d = cyc;
    pll_locked = 1'b0;
    goto(d + 1);
    pll_locked = 1'b1;
    push(d + 2,  2,  9'b1111_1_0_011, "drop_run");
    push(d + 3,  3,  9'b0000_0_1_100, "drop_run");
    push(d + 18, 18, 9'b0000_0_1_100, "drop_run");
    t0 = d + 19;
    push_table(t0, 1'b1, 99, "sticky");

    // Sticky flag survives a soft reset too.
    goto(t0 + 56);
    s = cyc;
    soft_rst = 1'b1;
    push(s + 1, 1, 9'b0000_0_1_100, "sticky_soft");
    t0 = s + 17;
    push_table(t0, 1'b1, 28, "sticky_soft");
    goto(s + 1);
    soft_rst = 1'b0;

    // Asynchronous rstn mid-release: outputs clear without a clock edge.
    goto(t0 + 30);
    #2;
    rstn = 1'b0;
    #1;
    act = {dom_rstn, ready, lock_lost, state_o};
    checks++;
    if (act !== 9'b0000_0_0_000) begin
      errors++;
      $display("FAIL async_rst: got dom=%b rdy=%b ll=%b st=%0d, want all zero",
               act[8:5], act[4], act[3], act[2:0]);
    end
    push(t0 + 31, 0, 9'b0000_0_0_000, "async_hold");
    goto(t0 + 32);
    rstn = 1'b1;
    k = cyc;
    push(k + 1, -1, 9'b0000_0_0_000, "async_restart");
    t0 = k + 2;
    push_table(t0, 1'b0, 99, "async_restart");

    // Lock glitch inside the filter window: filter restarts from the last rise.
    goto(t0 + 54);
    rstn       = 1'b0;
    pll_locked = 1'b0;
    goto(cyc + 2);
    rstn = 1'b1;
    goto(cyc + 6);
    a = cyc;
    pll_locked = 1'b1;
    goto(a + 3);
    pll_locked = 1'b0;
    goto(a + 4);
    pll_locked = 1'b1;
    push(a + 5, -1, 9'b0000_0_0_000, "glitch");
    t0 = a + 6;
    push_table(t0, 1'b0, 99, "glitch");

    goto(t0 + 54);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d scoreboard entries left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
